// File: rtl/carousel_pkg.sv
// Shared types for the carousel round sequencer.
// The round FSM walks GATHER -> ROTATE (skipped when rot_amt is 0) -> DRAIN.
package carousel_pkg;

  typedef enum logic [1:0] {
    GATHER = 2'd0,
    ROTATE = 2'd1,
    DRAIN  = 2'd2
  } carousel_seq_state_t;

endpackage

// File: rtl/carousel_lane_barrier.sv
// Sticky per-lane completion vector: collects one fire per lane until cleared.
// all_done also counts same-cycle fires so the FSM can advance on the last one.
module carousel_lane_barrier #(
  parameter int NUM_LANES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] fire,
  input  logic                 clear,
  output logic [NUM_LANES-1:0] pending,
  output logic                 all_done
);

  logic [NUM_LANES-1:0] done;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      done <= '0;
    end else begin
      done <= done | fire;
    end
  end

  assign pending  = ~done;
  assign all_done = &(done | fire);

endmodule

// File: rtl/carousel_round_sequencer.sv
// Round sequencer for the carousel datapath: gather one beat per lane, rotate, drain.
// Optional performance counters are built only when CAROUSEL_SEQ_PERF_EN is defined.
module carousel_round_sequencer
  import carousel_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int ROT_W     = 2,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] in_valid,
  output logic [NUM_LANES-1:0] in_ready,
  output logic [NUM_LANES-1:0] capture_en,
  input  logic [ROT_W-1:0]     rot_amt,
  output logic                 rotate_en,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 busy,
  output logic                 round_done,
  output logic [PERF_W-1:0]    perf_rounds,
  output logic [PERF_W-1:0]    perf_stall
);

  carousel_seq_state_t state;
  logic [ROT_W-1:0]     rot_cnt;
  logic [NUM_LANES-1:0] got_pending;
  logic [NUM_LANES-1:0] sent_pending;
  logic                 got_all;
  logic                 sent_all;
  logic [NUM_LANES-1:0] send_fire;

  // Handshake outputs decode only from flops; rst forces them quiet so a
  // mid-round reset never leaks a strobe into the datapath.
  always_comb begin
    in_ready   = '0;
    out_valid  = '0;
    rotate_en  = 1'b0;
    busy       = 1'b0;
    round_done = 1'b0;
    if (!rst) begin
      if (state == GATHER) in_ready = got_pending;
      if (state == DRAIN)  out_valid = sent_pending;
      rotate_en  = (state == ROTATE);
      busy       = !((state == GATHER) && (&got_pending));
      round_done = (state == DRAIN) && sent_all;
    end
  end

  assign capture_en = in_valid & in_ready;
  assign send_fire  = out_valid & out_ready;

  carousel_lane_barrier #(.NUM_LANES(NUM_LANES)) u_gather (
    .clk      (clk),
    .rst      (rst),
    .fire     (capture_en),
    .clear    (round_done),
    .pending  (got_pending),
    .all_done (got_all)
  );

  carousel_lane_barrier #(.NUM_LANES(NUM_LANES)) u_drain (
    .clk      (clk),
    .rst      (rst),
    .fire     (send_fire),
    .clear    (round_done),
    .pending  (sent_pending),
    .all_done (sent_all)
  );

  // rot_amt is latched only on the final-capture cycle; rot_cnt counts remaining strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= GATHER;
      rot_cnt <= '0;
    end else begin
      case (state)
        GATHER: begin
          if (got_all) begin
            if (rot_amt == '0) begin
              state <= DRAIN;
            end else begin
              rot_cnt <= rot_amt;
              state   <= ROTATE;
            end
          end
        end
        ROTATE: begin
          rot_cnt <= rot_cnt - 1'b1;
          if (rot_cnt == ROT_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          if (sent_all) state <= GATHER;
        end
        default: state <= GATHER;
      endcase
    end
  end

`ifdef CAROUSEL_SEQ_PERF_EN
  logic [PERF_W-1:0] rounds_q;
  logic [PERF_W-1:0] stall_q;
  logic              stall_cycle;

  assign stall_cycle = (state == DRAIN) && (|(out_valid & ~out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      rounds_q <= '0;
      stall_q  <= '0;
    end else begin
      if (round_done && !(&rounds_q)) rounds_q <= rounds_q + 1'b1;
      if (stall_cycle && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_rounds = rst ? '0 : rounds_q;
  assign perf_stall  = rst ? '0 : stall_q;
`else
  assign perf_rounds = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_carousel_round_sequencer.sv
// Self-checking bench for carousel_round_sequencer: directed table, corner sequences, random run.
// Expects perf counters live when CAROUSEL_SEQ_PERF_EN is defined, zero otherwise.
module tb_carousel_round_sequencer;

  localparam int N = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  capture_en;
  logic [1:0]    rot_amt;
  logic          rotate_en;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic          busy;
  logic          round_done;
  logic [31:0]   perf_rounds;
  logic [31:0]   perf_stall;

  carousel_round_sequencer #(.NUM_LANES(N), .ROT_W(2), .PERF_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .capture_en  (capture_en),
    .rot_amt     (rot_amt),
    .rotate_en   (rotate_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .round_done  (round_done),
    .perf_rounds (perf_rounds),
    .perf_stall  (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] iv;
    logic [N-1:0] ordy;
    logic [1:0]   rot;
    logic [N-1:0] e_ir;
    logic [N-1:0] e_cap;
    logic         e_rot;
    logic [N-1:0] e_ov;
    logic         e_busy;
    logic         e_rd;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: phase 0/1/2 = gathering/rotating/draining, lane flags as bit arrays.
  int phase     = 0;
  bit got  [N];
  bit sent [N];
  int rot_left  = 0;
  longint rounds = 0;
  longint stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    logic [N-1:0] m_ir, m_cap, m_ov;
    logic         m_rot, m_busy, m_rd, stalled;
    int           n_got, n_after_cap, n_after_send;
    logic [31:0]  e_pr, e_ps;
    rst = v.rst; in_valid = v.iv; out_ready = v.ordy; rot_amt = v.rot;
    @(negedge clk);
    m_ir = '0; m_cap = '0; m_ov = '0; m_rot = 0; m_busy = 0; m_rd = 0; stalled = 0;
    n_got = 0; n_after_cap = 0; n_after_send = 0;
    if (!v.rst) begin
      for (int i = 0; i < N; i++) begin
        m_ir[i]  = (phase == 0) && !got[i];
        m_cap[i] = v.iv[i] && m_ir[i];
        m_ov[i]  = (phase == 2) && !sent[i];
        if (got[i]) n_got++;
        if (got[i] || m_cap[i]) n_after_cap++;
        if (sent[i] || (m_ov[i] && v.ordy[i])) n_after_send++;
        if (m_ov[i] && !v.ordy[i]) stalled = 1;
      end
      m_rot  = (phase == 1);
      m_busy = !(phase == 0 && n_got == 0);
      m_rd   = (phase == 2) && (n_after_send == N);
    end
`ifdef CAROUSEL_SEQ_PERF_EN
    e_pr = v.rst ? 32'd0 : 32'(rounds);
    e_ps = v.rst ? 32'd0 : 32'(stalls);
`else
    e_pr = 32'd0;
    e_ps = 32'd0;
`endif
    chk("in_ready", 32'(in_ready), 32'(m_ir));
    chk("capture_en", 32'(capture_en), 32'(m_cap));
    chk("rotate_en", 32'(rotate_en), 32'(m_rot));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("round_done", 32'(round_done), 32'(m_rd));
    chk("perf_rounds", perf_rounds, e_pr);
    chk("perf_stall", perf_stall, e_ps);
    if (use_tbl) begin
      chk("tbl_in_ready", 32'(in_ready), 32'(v.e_ir));
      chk("tbl_capture_en", 32'(capture_en), 32'(v.e_cap));
      chk("tbl_rotate_en", 32'(rotate_en), 32'(v.e_rot));
      chk("tbl_out_valid", 32'(out_valid), 32'(v.e_ov));
      chk("tbl_busy", 32'(busy), 32'(v.e_busy));
      chk("tbl_round_done", 32'(round_done), 32'(v.e_rd));
    end
    // advance the model
    if (v.rst) begin
      phase = 0; rot_left = 0; rounds = 0; stalls = 0;
      for (int i = 0; i < N; i++) begin got[i] = 0; sent[i] = 0; end
    end else begin
      if (stalled && stalls < 64'hFFFF_FFFF) stalls++;
      case (phase)
        0: begin
          for (int i = 0; i < N; i++) if (m_cap[i]) got[i] = 1;
          if (n_after_cap == N) begin
            if (v.rot == 0) phase = 2;
            else begin rot_left = int'(v.rot); phase = 1; end
          end
        end
        1: begin
          rot_left--;
          if (rot_left == 0) phase = 2;
        end
        default: begin
          for (int i = 0; i < N; i++) if (m_ov[i] && v.ordy[i]) sent[i] = 1;
          if (m_rd) begin
            if (rounds < 64'hFFFF_FFFF) rounds++;
            phase = 0;
            for (int i = 0; i < N; i++) begin got[i] = 0; sent[i] = 0; end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] iv, input logic [N-1:0] ordy,
                       input logic [1:0] ra);
    vec_t v;
    v = '{r, iv, ordy, ra, 3'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b0};
    step(v, 1'b0);
  endtask

  initial begin
    vec_t tbl[$];
    rst = 1'b1; in_valid = '0; out_ready = '0; rot_amt = '0;

    //              rst iv      ordy    rot    e_ir    e_cap   rot  e_ov    busy rd
    tbl.push_back('{1, 3'b000, 3'b000, 2'd0, 3'b000, 3'b000, 0, 3'b000, 0, 0});
    tbl.push_back('{1, 3'b111, 3'b111, 2'd0, 3'b000, 3'b000, 0, 3'b000, 0, 0});
    tbl.push_back('{1, 3'b000, 3'b000, 2'd2, 3'b000, 3'b000, 0, 3'b000, 0, 0});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd2, 3'b111, 3'b000, 0, 3'b000, 0, 0});
    tbl.push_back('{0, 3'b001, 3'b000, 2'd2, 3'b111, 3'b001, 0, 3'b000, 0, 0});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd2, 3'b110, 3'b000, 0, 3'b000, 1, 0});
    tbl.push_back('{0, 3'b100, 3'b000, 2'd2, 3'b110, 3'b100, 0, 3'b000, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd2, 3'b010, 3'b000, 0, 3'b000, 1, 0});
    tbl.push_back('{0, 3'b010, 3'b000, 2'd2, 3'b010, 3'b010, 0, 3'b000, 1, 0});
    tbl.push_back('{0, 3'b111, 3'b000, 2'd3, 3'b000, 3'b000, 1, 3'b000, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd0, 3'b000, 3'b000, 1, 3'b000, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b100, 2'd0, 3'b000, 3'b000, 0, 3'b111, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd0, 3'b000, 3'b000, 0, 3'b011, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b001, 2'd0, 3'b000, 3'b000, 0, 3'b011, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd0, 3'b000, 3'b000, 0, 3'b010, 1, 0});
    tbl.push_back('{0, 3'b000, 3'b010, 2'd0, 3'b000, 3'b000, 0, 3'b010, 1, 1});
    tbl.push_back('{0, 3'b111, 3'b000, 2'd0, 3'b111, 3'b111, 0, 3'b000, 0, 0});
    tbl.push_back('{0, 3'b000, 3'b111, 2'd3, 3'b000, 3'b000, 0, 3'b111, 1, 1});
    tbl.push_back('{0, 3'b000, 3'b000, 2'd0, 3'b111, 3'b000, 0, 3'b000, 0, 0});

    #1;
    foreach (tbl[k]) step(tbl[k], 1'b1);

    // Reset in the second ROTATE cycle with rot_amt=3, then a clean round.
    drive(1'b0, 3'b111, 3'b000, 2'd3);
    drive(1'b0, 3'b000, 3'b000, 2'd0);
    drive(1'b1, 3'b000, 3'b111, 2'd0);
    drive(1'b0, 3'b000, 3'b111, 2'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'h7);
    drive(1'b0, 3'b000, 3'b000, 2'd0);
    chk("post_rst_rotate_en", 32'(rotate_en), 32'h0);
    drive(1'b0, 3'b111, 3'b000, 2'd1);
    drive(1'b0, 3'b000, 3'b000, 2'd0);
    drive(1'b0, 3'b000, 3'b111, 2'd0);

    // Three back-to-back rounds after reset, lane1 stalled 4 DRAIN cycles in round 2.
    drive(1'b1, 3'b000, 3'b000, 2'd0);
    drive(1'b0, 3'b111, 3'b111, 2'd1);
    drive(1'b0, 3'b000, 3'b111, 2'd0);
    drive(1'b0, 3'b000, 3'b111, 2'd0);
    drive(1'b0, 3'b111, 3'b101, 2'd1);
    drive(1'b0, 3'b000, 3'b101, 2'd0);
    drive(1'b0, 3'b000, 3'b101, 2'd0);
    drive(1'b0, 3'b000, 3'b000, 2'd0);
    drive(1'b0, 3'b000, 3'b101, 2'd0);
    drive(1'b0, 3'b000, 3'b101, 2'd0);
    drive(1'b0, 3'b000, 3'b111, 2'd0);
    drive(1'b0, 3'b111, 3'b111, 2'd1);
    drive(1'b0, 3'b000, 3'b111, 2'd0);
    drive(1'b0, 3'b000, 3'b111, 2'd0);
    drive(1'b0, 3'b000, 3'b000, 2'd0);
`ifdef CAROUSEL_SEQ_PERF_EN
    chk("perf_rounds_3", perf_rounds, 32'd3);
    chk("perf_stall_4", perf_stall, 32'd4);
`else
    chk("perf_rounds_off", perf_rounds, 32'd0);
    chk("perf_stall_off", perf_stall, 32'd0);
`endif

    // Random traffic with occasional resets, checked cycle by cycle against the model.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 59) == 0),
            3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
